// File: rtl/soc_io_responder.sv
// Memory-mapped I/O responder for the RV32 data bus: LED, debounced SW, CYCLES counter and SCRATCH word.
// Optional feature macro SOC_IO_IRQ_EN adds a sticky switch-change interrupt output 'irq'.
module soc_io_responder #(
    parameter int WAIT_STATES     = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    input  logic [2:0]  SW,
    output logic [7:0]  LED
`ifdef SOC_IO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic [3:0]        wcnt;
    logic [31:0]       scratch;
    logic [31:0]       cycles;
    logic [2:0]        sw_s1, sw_s2, sw_deb;
    logic [DBW-1:0]    dcnt;

    logic [1:0]        lat_reg;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_wmask;
    logic              lat_wr;

    logic              sel, wr_req, accept, done, deb_load;
    logic [1:0]        op_reg;
    logic [31:0]       op_wdata;
    logic [3:0]        op_wmask;
    logic              op_wr;
    logic [31:0]       rd_val;

    wire unused_addr = &{1'b0, mem_addr[31:23], mem_addr[21:4], mem_addr[1:0]};

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = mask[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

    assign sel      = mem_addr[22];
    assign wr_req   = |mem_wmask;
    assign accept   = (state == S_IDLE) && sel && (wr_req || mem_rstrb);
    assign done     = ((state == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (wcnt == 4'd0));
    assign deb_load = (sw_s2 != sw_deb) && (dcnt == DB_LAST);

    // In IDLE the live bus is the operation (zero-wait); in WAIT it is the request latched at accept.
    always_comb begin
        op_reg   = lat_reg;
        op_wdata = lat_wdata;
        op_wmask = lat_wmask;
        op_wr    = lat_wr;
        if (state == S_IDLE) begin
            op_reg   = mem_addr[3:2];
            op_wdata = mem_wdata;
            op_wmask = mem_wmask;
            op_wr    = wr_req;
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (op_reg)
            2'd0: rd_val = {24'd0, LED};
            2'd1: rd_val = {29'd0, sw_deb};
            2'd2: rd_val = cycles;
            2'd3: rd_val = scratch;
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            lat_reg   <= mem_addr[3:2];
            lat_wdata <= mem_wdata;
            lat_wmask <= mem_wmask;
            lat_wr    <= wr_req;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            mem_rbusy <= 1'b0;
            mem_wbusy <= 1'b0;
            mem_rdata <= 32'd0;
            LED       <= 8'd0;
            scratch   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (WAIT_STATES != 0)) begin
                        state     <= S_WAIT;
                        wcnt      <= WS_INIT;
                        mem_rbusy <= ~wr_req;
                        mem_wbusy <= wr_req;
                    end
                end
                S_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state     <= S_IDLE;
                        mem_rbusy <= 1'b0;
                        mem_wbusy <= 1'b0;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Completion: register update or read capture, same edge busy falls.
            if (done) begin
                if (op_wr) begin
                    if (op_reg == 2'd0 && op_wmask[0]) LED <= op_wdata[7:0];
                    if (op_reg == 2'd3) scratch <= merge_lanes(scratch, op_wdata, op_wmask);
                end else begin
                    mem_rdata <= rd_val;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) cycles <= 32'd0;
        else         cycles <= cycles + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sw_s1  <= 3'd0;
            sw_s2  <= 3'd0;
            sw_deb <= 3'd0;
            dcnt   <= '0;
        end else begin
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
            if (sw_s2 == sw_deb) begin
                dcnt <= '0;
            end else if (deb_load) begin
                sw_deb <= sw_s2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

`ifdef SOC_IO_IRQ_EN
    // A change landing on the same edge as the clearing SW read keeps the flag set.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)                                   irq <= 1'b0;
        else if (deb_load)                             irq <= 1'b1;
        else if (done && !op_wr && op_reg == 2'd1)     irq <= 1'b0;
    end
`endif

endmodule
